// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types for the MIPS memory stage (pipe bundles, data bus
//               request/response, memory FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        u32         pc_plus_4;
        u32         pc_branch;
        u32         alu_result;
        logic       zero;
        u32         write_data;
        creg_addr_t write_reg;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } e_m_reg_t;

    typedef struct packed {
        u32         alu_result;
        u32         read_data;
        creg_addr_t write_reg;
        logic       reg_write;
        logic       mem_to_reg;
    } m_w_reg_t;

    typedef struct packed {
        logic       valid;
        u32         addr;
        logic [3:0] strobe;
        u32         data;
    } dbus_req_t;

    typedef struct packed {
        logic       valid;
        u32         data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    localparam logic [3:0] STROBE_WORD = 4'hF;

    function automatic u32 word_addr(input u32 a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_dbus_ctrl.sv
// ============================================================================
// Module      : dbus_ctrl
// Description : Data-bus FSM for the memory stage: issues the word request,
//               waits for the response and holds the captured read data.
//               Optional build macro: MEM_MISALIGN_CHECK_EN (via misalign_i).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_ctrl
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_i,
    input  logic       mem_op_i,
    input  logic       misalign_i,
    input  u32         addr_i,
    input  u32         wdata_i,
    input  logic       mem_write_i,
    output dbus_req_t  dreq_o,
    input  logic       dreq_ready_i,
    input  dbus_resp_t dresp_i,
    output logic       stall_req_o,
    output u32         rdata_o
);

    mem_state_t state_q, state_d;
    u32         rdata_q, rdata_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // A stage advance always restarts the FSM for the newly latched entry.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            if (misalign_i)    state_d = DONE;
            else if (mem_op_i) state_d = REQ;
            else               state_d = IDLE;
        end else begin
            case (state_q)
                REQ:     if (dreq_ready_i)  state_d = WAIT;
                WAIT:    if (dresp_i.valid) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Read data is cleared on every advance so bubbles carry no stale load.
    always_comb begin
        rdata_d = rdata_q;
        if (load_i)
            rdata_d = '0;
        else if (state_q == WAIT && dresp_i.valid)
            rdata_d = dresp_i.data;
    end

    always_comb begin
        dreq_o      = '0;
        stall_req_o = 1'b0;
        case (state_q)
            REQ: begin
                dreq_o.valid  = 1'b1;
                dreq_o.addr   = addr_i;
                dreq_o.strobe = mem_write_i ? STROBE_WORD : 4'h0;
                dreq_o.data   = wdata_i;
                stall_req_o   = 1'b1;
            end
            WAIT:    stall_req_o = 1'b1;
            default: stall_req_o = 1'b0;
        endcase
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : MIPS memory pipeline stage: stage register, branch/jump
//               redirect, forwarding and data-bus access via dbus_ctrl.
//               Optional build macro: MEM_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  e_m_reg_t   e_m_reg,
    input  logic       stallM,
    input  logic       flushM,
    output dbus_req_t  dreq,
    input  logic       dreq_ready,
    input  dbus_resp_t dresp,
    output m_w_reg_t   m_w_reg,
    output u32         mem_forward_data,
    output logic       pc_src,
    output u32         pc_target,
    output logic       stall_req,
    output creg_addr_t write_regM,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic       misalign,
`endif
    output logic       reg_writeM
);

    e_m_reg_t e_m_q, e_m_d;
    logic     w_advance;
    logic     w_in_mem_op;
    logic     w_in_misalign;
    logic     w_suppress;
    u32       w_rdata;
    logic     w_unused;

    // Busy state also gates the advance locally, so a flush cannot cut a transaction.
    assign w_advance = !stallM && !stall_req;
    assign e_m_d     = w_advance ? (flushM ? '0 : e_m_reg) : e_m_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) e_m_q <= '0;
        else         e_m_q <= e_m_d;
    end

    assign w_in_mem_op = (e_m_reg.mem_to_reg | e_m_reg.mem_write) & ~flushM;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_in_misalign = w_in_mem_op & (|e_m_reg.alu_result[1:0]);
    assign misalign      = (e_m_q.mem_to_reg | e_m_q.mem_write) & (|e_m_q.alu_result[1:0]);
    assign w_suppress    = misalign;
`else
    assign w_in_misalign = 1'b0;
    assign w_suppress    = 1'b0;
`endif

    dbus_ctrl u_dbus_ctrl (
        .clk          (clk),
        .resetn       (resetn),
        .load_i       (w_advance),
        .mem_op_i     (w_in_mem_op),
        .misalign_i   (w_in_misalign),
        .addr_i       (word_addr(e_m_q.alu_result)),
        .wdata_i      (e_m_q.write_data),
        .mem_write_i  (e_m_q.mem_write),
        .dreq_o       (dreq),
        .dreq_ready_i (dreq_ready),
        .dresp_i      (dresp),
        .stall_req_o  (stall_req),
        .rdata_o      (w_rdata)
    );

    assign m_w_reg.alu_result = e_m_q.alu_result;
    assign m_w_reg.read_data  = w_rdata;
    assign m_w_reg.write_reg  = e_m_q.write_reg;
    assign m_w_reg.reg_write  = e_m_q.reg_write & ~w_suppress;
    assign m_w_reg.mem_to_reg = e_m_q.mem_to_reg;

    assign mem_forward_data = e_m_q.alu_result;
    assign pc_src           = (e_m_q.branch & e_m_q.zero) | e_m_q.jump;
    assign pc_target        = e_m_q.pc_branch;
    assign write_regM       = e_m_q.write_reg;
    assign reg_writeM       = m_w_reg.reg_write;

    assign w_unused = ^e_m_q.pc_plus_4;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage; acts as the
//               hazard unit (stallM = stall_req | extra hold) and data bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    e_m_reg_t   e_m_reg;
    logic       stall_ext;
    logic       stallM;
    logic       flushM;
    dbus_req_t  dreq;
    logic       dreq_ready;
    dbus_resp_t dresp;
    m_w_reg_t   m_w_reg;
    u32         mem_forward_data;
    logic       pc_src;
    u32         pc_target;
    logic       stall_req;
    creg_addr_t write_regM;
    logic       reg_writeM;
`ifdef MEM_MISALIGN_CHECK_EN
    logic       misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    always #5 clk = ~clk;

    assign stallM = stall_req | stall_ext;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .e_m_reg          (e_m_reg),
        .stallM           (stallM),
        .flushM           (flushM),
        .dreq             (dreq),
        .dreq_ready       (dreq_ready),
        .dresp            (dresp),
        .m_w_reg          (m_w_reg),
        .mem_forward_data (mem_forward_data),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .stall_req        (stall_req),
        .write_regM       (write_regM),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign         (misalign),
`endif
        .reg_writeM       (reg_writeM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic e_m_reg_t mk_mem(input u32 addr, input u32 wd, input logic wr,
                                        input creg_addr_t rd);
        e_m_reg_t e;
        e            = '0;
        e.alu_result = addr;
        e.write_data = wd;
        e.mem_write  = wr;
        e.mem_to_reg = ~wr;
        e.reg_write  = ~wr;
        e.write_reg  = rd;
        return e;
    endfunction

    // Called at the negedge of the first cycle after the entry is latched.
    task automatic run_mem(input int ready_delay, input int resp_delay, input u32 rdata,
                           input u32 exp_addr, input logic [3:0] exp_strobe, input u32 exp_data,
                           input logic flush_in_wait, output int n_stall);
        int req_cyc  = 0;
        int wait_cyc = 0;
        n_stall = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall_req) break;
            n_stall++;
            if (dreq.valid) begin
                req_cyc++;
                check("req_addr", dreq.addr, exp_addr);
                check("req_strobe", {28'd0, dreq.strobe}, {28'd0, exp_strobe});
                check("req_data", dreq.data, exp_data);
                dreq_ready = (req_cyc > ready_delay);
            end else begin
                dreq_ready = 1'b0;
                wait_cyc++;
                if (flush_in_wait) flushM = 1'b1;
                if (wait_cyc > resp_delay) begin
                    dresp.valid = 1'b1;
                    dresp.data  = rdata;
                end
            end
            @(negedge clk);
            dresp.valid = 1'b0;
        end
        check("mem_timeout_stall", {31'd0, stall_req}, 32'd0);
        dreq_ready = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        e_m_reg    = '0;
        stall_ext  = 1'b0;
        flushM     = 1'b0;
        dreq_ready = 1'b0;
        dresp      = '0;

        #3;
        check("rst_dreq", {31'd0, dreq.valid}, 32'd0);
        check("rst_dreq_all", {31'd0, (dreq == '0)}, 32'd1);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_pc_src", {31'd0, pc_src}, 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        check("rst_mw", {31'd0, (m_w_reg == '0)}, 32'd1);
        check("rst_fwd", mem_forward_data, 32'd0);

        @(negedge clk);
        resetn = 1'b1;

        // Load, zero-wait
        e_m_reg    = mk_mem(32'h100, 32'h0, 1'b0, 5'd5);
        dreq_ready = 1'b1;
        @(negedge clk);
        e_m_reg = '0;
        run_mem(0, 0, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0, 1'b0, stalls);
        check("ld_stalls", stalls, 32'd2);
        check("ld_rdata", m_w_reg.read_data, 32'hDEADBEEF);
        check("ld_fwd", mem_forward_data, 32'h100);
        check("ld_wreg", {27'd0, write_regM}, 32'd5);
        check("ld_regw", {31'd0, reg_writeM}, 32'd1);
        check("ld_m2r", {31'd0, m_w_reg.mem_to_reg}, 32'd1);

        // Store with 3 cycles of backpressure
        e_m_reg = mk_mem(32'h204, 32'h12345678, 1'b1, 5'd0);
        @(negedge clk);
        e_m_reg = '0;
        check("st_rdata_clr", m_w_reg.read_data, 32'd0);
        run_mem(3, 0, 32'h0, 32'h204, 4'hF, 32'h12345678, 1'b0, stalls);
        check("st_stalls", stalls, 32'd5);
        check("st_regw", {31'd0, reg_writeM}, 32'd0);

`ifndef MEM_MISALIGN_CHECK_EN
        // Unaligned address is masked to the word
        e_m_reg = mk_mem(32'h10B, 32'h0, 1'b0, 5'd2);
        @(negedge clk);
        e_m_reg = '0;
        run_mem(0, 0, 32'hCAFEF00D, 32'h108, 4'h0, 32'h0, 1'b0, stalls);
        check("mask_stalls", stalls, 32'd2);
        check("mask_rdata", m_w_reg.read_data, 32'hCAFEF00D);
`endif

        // Branch taken, then branch not taken, then jump; one per cycle
        e_m_reg           = '0;
        e_m_reg.branch    = 1'b1;
        e_m_reg.zero      = 1'b1;
        e_m_reg.pc_branch = 32'h0040_0020;
        @(negedge clk);
        check("br_pc_src", {31'd0, pc_src}, 32'd1);
        check("br_target", pc_target, 32'h0040_0020);
        check("br_stall", {31'd0, stall_req}, 32'd0);
        check("br_dreq", {31'd0, dreq.valid}, 32'd0);
        e_m_reg            = '0;
        e_m_reg.branch     = 1'b1;
        e_m_reg.alu_result = 32'h11;
        @(negedge clk);
        check("bnt_pc_src", {31'd0, pc_src}, 32'd0);
        check("bnt_fwd", mem_forward_data, 32'h11);
        e_m_reg            = '0;
        e_m_reg.jump       = 1'b1;
        e_m_reg.pc_branch  = 32'h0040_0100;
        e_m_reg.alu_result = 32'h22;
        @(negedge clk);
        check("j_pc_src", {31'd0, pc_src}, 32'd1);
        check("j_target", pc_target, 32'h0040_0100);
        check("j_fwd", mem_forward_data, 32'h22);

        // External hold keeps the stage register
        stall_ext          = 1'b1;
        e_m_reg            = '0;
        e_m_reg.alu_result = 32'h33;
        @(negedge clk);
        check("hold_fwd", mem_forward_data, 32'h22);
        stall_ext = 1'b0;
        @(negedge clk);
        check("rel_fwd", mem_forward_data, 32'h33);

        // Flush during WAIT: transaction completes, then a bubble loads
        e_m_reg = mk_mem(32'h300, 32'h0, 1'b0, 5'd7);
        @(negedge clk);
        e_m_reg            = '0;
        e_m_reg.alu_result = 32'h77;
        e_m_reg.reg_write  = 1'b1;
        e_m_reg.write_reg  = 5'd9;
        run_mem(0, 2, 32'hA5A5A5A5, 32'h300, 4'h0, 32'h0, 1'b1, stalls);
        check("fl_stalls", stalls, 32'd4);
        check("fl_rdata", m_w_reg.read_data, 32'hA5A5A5A5);
        check("fl_fwd_held", mem_forward_data, 32'h300);
        @(negedge clk);
        flushM = 1'b0;
        check("fl_bubble_mw", {31'd0, (m_w_reg == '0)}, 32'd1);
        check("fl_bubble_fwd", mem_forward_data, 32'd0);
        check("fl_bubble_stall", {31'd0, stall_req}, 32'd0);

        // Reset in the middle of a request
        e_m_reg    = mk_mem(32'h400, 32'h0000BBBB, 1'b1, 5'd0);
        dreq_ready = 1'b0;
        @(negedge clk);
        e_m_reg = '0;
        check("rr_req_valid", {31'd0, dreq.valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rr_dreq_drop", {31'd0, dreq.valid}, 32'd0);
        check("rr_stall_drop", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        resetn      = 1'b1;
        dresp.valid = 1'b1;
        dresp.data  = 32'h00000BAD;
        @(negedge clk);
        dresp.valid = 1'b0;
        check("rr_stray_rdata", m_w_reg.read_data, 32'd0);
        check("rr_idle_stall", {31'd0, stall_req}, 32'd0);
        check("rr_idle_dreq", {31'd0, dreq.valid}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned load completes with no bus request
        e_m_reg = mk_mem(32'h102, 32'h0, 1'b0, 5'd3);
        @(negedge clk);
        e_m_reg = '0;
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_dreq", {31'd0, dreq.valid}, 32'd0);
        check("mis_stall", {31'd0, stall_req}, 32'd0);
        check("mis_regw", {31'd0, m_w_reg.reg_write}, 32'd0);
        check("mis_rdata", m_w_reg.read_data, 32'd0);
        @(negedge clk);
        check("mis_clear", {31'd0, misalign}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory pipeline stage of the five-stage MIPS core. It receives the execute-to-memory bundle (`e_m_reg_t`) and registers it. Loads and stores go to the data bus through a valid/ready request and valid response handshake. The block also resolves the branch/jump redirect, drives forwarding data back to execute, and emits the memory-to-writeback bundle (`m_w_reg_t`).

## Interface
- No parameters; all widths come from `common` (`u32`, `creg_addr_t`) and `pipes`.
- `clk` in 1: core clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `e_m_reg` in `e_m_reg_t`: fields `pc_plus_4`, `pc_branch`, `alu_result`, `zero`, `write_data`, `write_reg`, `reg_write`, `mem_to_reg`, `mem_write`, `branch`, `jump`.
- `stallM` in 1: hold the stage register (from hazard unit).
- `flushM` in 1: load a bubble on the next advance.
- `dreq` out `dbus_req_t`: `valid`, `addr[31:0]`, `strobe[3:0]`, `data[31:0]`.
- `dreq_ready` in 1: bus accepts the request this cycle.
- `dresp` in `dbus_resp_t`: `valid`, `data[31:0]`; load data or store acknowledge.
- `m_w_reg` out `m_w_reg_t`: `alu_result`, `read_data`, `write_reg`, `reg_write`, `mem_to_reg`.
- `mem_forward_data` out `u32`: `resultM`, equal to the latched `alu_result`.
- `pc_src` out 1: `(branch & zero) | jump` of the latched entry.
- `pc_target` out `u32`: latched `pc_branch`.
- `stall_req` out 1: the stage is busy on the bus.
- `write_regM` out `creg_addr_t`; `reg_writeM` out 1: these go to the hazard unit.

## Operation
- Stage register `e_m` has two update rules.
  - Async reset clears it to all zeros, which is a bubble.
  - At posedge, when `!stallM`, it loads `flushM ? '0 : e_m_reg`.
- A memory op is `mem_to_reg | mem_write` of the latched entry. All accesses are word accesses.
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
  - On an advancing edge, the next state is REQ if the incoming entry is a memory op and not flushed; otherwise it is IDLE. This overrides the rules below.
  - REQ: `dreq.valid=1`, `addr={alu_result[31:2],2'b00}`, `strobe=mem_write?4'hF:4'h0`, `data=write_data`. On `dreq_ready`, go to WAIT. Fields stay stable until accepted.
  - WAIT: on `dresp.valid`, capture `dresp.data` into `rdata_q`, then go to DONE.
  - DONE: hold `rdata_q` until the next advance.
- `stall_req = (state==REQ) | (state==WAIT)`. The hazard unit ORs it into `stallM` and the upstream stalls.
- `dresp.valid` in IDLE, REQ or DONE is ignored. Responses never arrive in the cycle of acceptance.
- `flushM` while in REQ or WAIT has no effect until the transaction completes. The bubble loads on the first advancing edge after that.
- `m_w_reg.read_data = rdata_q`. Every other `m_w_reg` field is the latched `e_m` value.
- `pc_src` and `pc_target` are combinational from `e_m` and are valid during the entry's whole residency.
- Reset mid-transaction goes to IDLE and deasserts `dreq.valid` immediately. The late response is dropped.

## Timing
- Reset values:
  - `dreq` all 0.
  - `stall_req` 0.
  - `pc_src` 0, `pc_target` 0.
  - `m_w_reg` all 0, `mem_forward_data` 0, `rdata_q` 0.
- Minimum memory latency is 2 cycles of `stall_req`. Example:
  - Entry latched at edge T.
  - REQ during cycle T with `dreq_ready=1`.
  - WAIT during T+1 with `dresp.valid=1`.
  - DONE at T+2, so `stall_req` is low in T+2.
- Each extra cycle without `dreq_ready` or `dresp.valid` extends `stall_req` by one cycle.
- Non-memory entries never stall. Stage throughput is one per cycle.
- `read_data` is valid only in DONE.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - If `alu_result[1:0]!=0` on a memory op, the FSM goes to DONE without issuing a request.
  - `rdata_q` is set to 0, and the stores' `reg_write`/`mem_write` are suppressed.
  - Output `misalign` (1 bit) is high while that entry is resident.
- Undefined: the low address bits are masked, the access proceeds, and there is no `misalign` port.

## Structure
- Add to `pipes`: `m_w_reg_t`, `dbus_req_t`, `dbus_resp_t`, and `mem_state_t` enum (IDLE, REQ, WAIT, DONE).
- Sub-module `dbus_ctrl` holds the FSM, request drive and `rdata_q`. Its inputs are the advance/load pulse and the op type. `mem_stage` holds the stage register and redirect logic.

## Test plan
- Load, zero-wait: latch lw with `alu_result=0x100`, `dreq_ready=1`, next cycle `dresp.data=0xDEADBEEF` -> `addr=0x100`, `strobe=0`, 2 stall cycles, `read_data=0xDEADBEEF`.
- Store with backpressure: sw with `write_data=0x12345678`, `dreq_ready` low for 3 cycles -> request fields stable, `strobe=4'hF`, `stall_req` high for 5 cycles.
- Branch taken: `branch=1`, `zero=1`, `pc_branch=0x400020` -> `pc_src=1`, `pc_target=0x400020`, no stall.
- Flush in WAIT: `flushM=1` during WAIT, `dresp` two cycles later -> transaction completes, then a bubble is latched with all-zero `m_w_reg`.
- Reset mid-REQ: drop `resetn` during REQ -> `dreq.valid=0` immediately, IDLE, and a stray `dresp.valid` is ignored.
- With `MEM_MISALIGN_CHECK_EN`: lw at `0x102` -> no `dreq.valid`, `misalign=1`, `reg_write=0`.
